z80_sram_bridge: RTL and testbench
==================================

Z80_SRAM_BRIDGE -- requirements
Module: z80_sram_bridge

Interface
REQ-001 SHALL provide parameter WAITS, default 1, meaning the number of extra clk cycles an SRAM access holds wait_n low (legal range 0..7).
REQ-002 SHALL provide port clk, input, 1 bit: single rising-edge clock shared with the CPU.
REQ-003 SHALL provide port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL provide input ports mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, each 1 bit: Z80 bus strobes.
REQ-005 SHALL provide port A, input, 16 bits: CPU address.
REQ-006 SHALL provide port dout, input, 8 bits: CPU write data.
REQ-007 SHALL provide port di, output, 8 bits, registered: CPU read data.
REQ-008 SHALL provide port wait_n, output, 1 bit, registered: CPU wait request.
REQ-009 SHALL provide ports sram_a (output, 16 bits), sram_d_o (output, 8 bits), sram_d_i (input, 8 bits), sram_we_n (output, 1 bit) and sram_oe_n (output, 1 bit): single-port SRAM; sram_d_i is valid on the clk edge after sram_oe_n goes low.
REQ-010 SHALL provide port ear, input, 1 bit: tape input.
REQ-011 SHALL provide port border, output, 3 bits; port mic, output, 1 bit; and port spk, output, 1 bit: the port 0xFE latch.

Function
REQ-012 SHALL implement states IDLE, MEM, HOLD; the state register SHALL update on rising clk only.
REQ-013 mem_start SHALL be defined as mreq_n=0, rfsh_n=1 and (rd_n=0 or wr_n=0); refresh cycles (rfsh_n=0) SHALL never start an access.
REQ-014 On a clk edge in IDLE with mem_start true, the block SHALL:
- load sram_a<=A;
- on a write (wr_n=0), load sram_d_o<=dout and set sram_we_n<=0;
- otherwise set sram_oe_n<=0;
- load cnt<=WAITS;
- set wait_n<=0 if WAITS>0;
- enter MEM.
REQ-015 In MEM with cnt>0, each clk edge SHALL decrement cnt and hold all SRAM outputs stable.
REQ-016 In MEM with cnt=0, the clk edge SHALL:
- capture di<=sram_d_i on a read;
- set sram_we_n<=1, sram_oe_n<=1 and wait_n<=1;
- enter HOLD.
REQ-017 With WAITS=0, wait_n SHALL stay 1 and an access SHALL occupy exactly one clk in MEM.
REQ-018 HOLD SHALL return to IDLE on the first clk edge where mreq_n=1 and iorq_n=1, so each CPU strobe yields exactly one SRAM access.
REQ-019 In IDLE, when iorq_n=0, m1_n=1, wr_n=0 and A[0]=0, the block SHALL latch border<=dout[2:0], mic<=dout[3] and spk<=dout[4] on that edge and enter HOLD, with no wait states.
REQ-020 In IDLE, when iorq_n=0, m1_n=1, rd_n=0 and A[0]=0, the block SHALL load di<={1'b1,ear,6'b111111} and enter HOLD.
REQ-021 Every other I/O read and every interrupt acknowledge (m1_n=0, iorq_n=0) SHALL load di<=8'hFF and enter HOLD.
REQ-022 If mreq_n=0 and iorq_n=0 both hold in IDLE, the memory access SHALL take priority.
REQ-023 A strobe that rises during MEM SHALL NOT abort the access; the access SHALL complete and the FSM SHALL then pass through HOLD normally.
REQ-024 The sram_we_n=0 and sram_oe_n=0 conditions SHALL be mutually exclusive in every cycle.

Reset
REQ-025 While reset_n=0, regardless of clk, the block SHALL force: state=IDLE, cnt=0, di=8'hFF, wait_n=1, sram_we_n=1, sram_oe_n=1, sram_a=16'h0000, sram_d_o=8'h00, border=3'b000, mic=0, spk=0.
REQ-026 Reset asserted mid-access SHALL abandon the access immediately, with no SRAM write completing after reset is asserted.
REQ-027 After reset_n rises, the first access SHALL require a fresh mem_start in IDLE.

Verification
REQ-028 The bench SHALL cover each of the following directed scenarios:
- Read, WAITS=1: SRAM[0x0001]=0x0F, CPU reads 0x0001 -> wait_n low for 1 clk, di=0x0F, sram_oe_n low for 2 clks.
- Write, WAITS=2: CPU writes 0x55 to 0x000F -> sram_we_n low for 3 clks with sram_a=0x000F and sram_d_o=0x55; wait_n low for 2 clks; exactly one write.
- Port 0xFE write: OUT (0xFE) with dout=0x1A -> border=3'b010, mic=1, spk=1; wait_n stays 1.
- Port 0xFE read with ear=0 -> di=0xBF; read of port 0x01 -> di=0xFF; interrupt acknowledge -> di=0xFF.
- Refresh cycle with mreq_n=0 and rfsh_n=0 -> no SRAM strobe and wait_n=1.
- Reset pulse during MEM of a write (WAITS=3) -> sram_we_n=1, wait_n=1 and border=0 within the same cycle; the SRAM location is unchanged if the write had not yet been sampled.

Source files
------------

// File: rtl/z80_sram_bridge.sv
// Z80 bus to single-port async SRAM bridge with WAITS-cycle wait insertion
// and the port 0xFE border/mic/speaker latch plus ear read-back.
module z80_sram_bridge #(
  parameter int unsigned WAITS = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic        rfsh_n,
  input  logic [15:0] A,
  input  logic [7:0]  dout,
  output logic [7:0]  di,
  output logic        wait_n,
  output logic [15:0] sram_a,
  output logic [7:0]  sram_d_o,
  input  logic [7:0]  sram_d_i,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  input  logic        ear,
  output logic [2:0]  border,
  output logic        mic,
  output logic        spk
);

  typedef enum logic [1:0] {IDLE, MEM, HOLD} state_t;

  localparam logic [2:0] WAITS_L = 3'(WAITS);

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [7:0]  di_nx, sram_d_o_nx;
  logic [15:0] sram_a_nx;
  logic        wait_nx, we_nx, oe_nx, mic_nx, spk_nx;
  logic [2:0]  border_nx;
  logic        mem_start;

  assign mem_start = !mreq_n && rfsh_n && (!rd_n || !wr_n);

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    di_nx       = di;
    wait_nx     = wait_n;
    sram_a_nx   = sram_a;
    sram_d_o_nx = sram_d_o;
    we_nx       = sram_we_n;
    oe_nx       = sram_oe_n;
    border_nx   = border;
    mic_nx      = mic;
    spk_nx      = spk;
    case (state)
      IDLE: begin
        // Memory wins over a simultaneous I/O strobe.
        if (mem_start) begin
          sram_a_nx = A;
          if (!wr_n) begin
            sram_d_o_nx = dout;
            we_nx       = 1'b0;
          end else begin
            oe_nx = 1'b0;
          end
          cnt_nx   = WAITS_L;
          wait_nx  = (WAITS == 0);
          state_nx = MEM;
        end else if (!iorq_n && !m1_n) begin
          di_nx    = 8'hFF;
          state_nx = HOLD;
        end else if (!iorq_n && !wr_n) begin
          if (!A[0]) begin
            border_nx = dout[2:0];
            mic_nx    = dout[3];
            spk_nx    = dout[4];
          end
          state_nx = HOLD;
        end else if (!iorq_n && !rd_n) begin
          di_nx    = A[0] ? 8'hFF : {1'b1, ear, 6'b111111};
          state_nx = HOLD;
        end
      end
      MEM: begin
        // wait_n releases one edge before the strobe so the CPU sees
        // exactly WAITS wait cycles while the strobe spans WAITS+1.
        if (cnt != 3'd0) begin
          cnt_nx = cnt - 3'd1;
          if (cnt == 3'd1) wait_nx = 1'b1;
        end else begin
          if (!sram_oe_n) di_nx = sram_d_i;
          we_nx    = 1'b1;
          oe_nx    = 1'b1;
          wait_nx  = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (mreq_n && iorq_n) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      di        <= 8'hFF;
      wait_n    <= 1'b1;
      sram_we_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_a    <= 16'h0000;
      sram_d_o  <= 8'h00;
      border    <= 3'b000;
      mic       <= 1'b0;
      spk       <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      di        <= di_nx;
      wait_n    <= wait_nx;
      sram_we_n <= we_nx;
      sram_oe_n <= oe_nx;
      sram_a    <= sram_a_nx;
      sram_d_o  <= sram_d_o_nx;
      border    <= border_nx;
      mic       <= mic_nx;
      spk       <= spk_nx;
    end
  end

endmodule

// File: tb/tb_z80_sram_bridge.sv
// Directed bench: four bridges (WAITS=0..3) share one CPU bus, each with
// its own async SRAM model; expectations are hand-computed constants.
module tb_z80_sram_bridge;
  logic clk = 1'b0;
  logic reset_n;
  logic mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, ear;
  logic [15:0] A;
  logic [7:0]  dout;

  logic [7:0]  di_w     [4];
  logic        wait_w   [4];
  logic [15:0] sa_w     [4];
  logic [7:0]  sdo_w    [4];
  logic [7:0]  sdi_w    [4];
  logic        we_w     [4];
  logic        oe_w     [4];
  logic [2:0]  border_w [4];
  logic        mic_w    [4];
  logic        spk_w    [4];

  int total = 0;
  int bad   = 0;
  int oe_lo [4];
  int we_lo [4];
  int wt_lo [4];
  int both_lo = 0;
  int w0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g
    logic [7:0] mem [256];
    int wcnt = 0;
    z80_sram_bridge #(.WAITS(k)) dut (
      .clk(clk), .reset_n(reset_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
      .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .rfsh_n(rfsh_n), .A(A),
      .dout(dout), .di(di_w[k]), .wait_n(wait_w[k]), .sram_a(sa_w[k]),
      .sram_d_o(sdo_w[k]), .sram_d_i(sdi_w[k]), .sram_we_n(we_w[k]),
      .sram_oe_n(oe_w[k]), .ear(ear), .border(border_w[k]),
      .mic(mic_w[k]), .spk(spk_w[k])
    );
    initial begin
      for (int j = 0; j < 256; j++) mem[j] = 8'h00;
      mem[1] = 8'h0F;
      mem[2] = 8'h3C;
    end
    assign sdi_w[k] = mem[sa_w[k][7:0]];
    always @(posedge clk) if (!we_w[k]) mem[sa_w[k][7:0]] <= sdo_w[k];
    always @(negedge we_w[k]) wcnt <= wcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic idle_bus();
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    m1_n = 1'b1; rfsh_n = 1'b1;
  endtask

  // Drive one bus cycle for ncyc clocks, tallying strobe/wait lows, then
  // release the bus and let every bridge settle back to IDLE.
  task automatic bus(input logic mq, input logic io, input logic rd, input logic wr,
                     input logic m1, input logic rf, input logic [15:0] a,
                     input logic [7:0] d, input int ncyc);
    for (int k = 0; k < 4; k++) begin oe_lo[k] = 0; we_lo[k] = 0; wt_lo[k] = 0; end
    @(negedge clk);
    mreq_n = mq; iorq_n = io; rd_n = rd; wr_n = wr; m1_n = m1; rfsh_n = rf;
    A = a; dout = d;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (!oe_w[k]) oe_lo[k]++;
        if (!we_w[k]) we_lo[k]++;
        if (!wait_w[k]) wt_lo[k]++;
        if (!oe_w[k] && !we_w[k]) both_lo++;
      end
    end
    idle_bus();
    repeat (6) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; idle_bus(); A = 16'h0; dout = 8'h0; ear = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_di",     32'(di_w[1]),     32'hFF);
    chk("rst_wait",   32'(wait_w[1]),   32'h1);
    chk("rst_we",     32'(we_w[1]),     32'h1);
    chk("rst_oe",     32'(oe_w[1]),     32'h1);
    chk("rst_sa",     32'(sa_w[1]),     32'h0);
    chk("rst_sdo",    32'(sdo_w[1]),    32'h0);
    chk("rst_border", 32'(border_w[1]), 32'h0);
    chk("rst_micspk", {30'd0, mic_w[1], spk_w[1]}, 32'h0);

    // Memory read of 0x0001
    bus(0, 1, 0, 1, 1, 1, 16'h0001, 8'h00, 8);
    chk("rd_w1_di",   32'(di_w[1]),  32'h0F);
    chk("rd_w1_oe",   32'(oe_lo[1]), 32'd2);
    chk("rd_w1_wait", 32'(wt_lo[1]), 32'd1);
    chk("rd_w0_di",   32'(di_w[0]),  32'h0F);
    chk("rd_w0_oe",   32'(oe_lo[0]), 32'd1);
    chk("rd_w0_wait", 32'(wt_lo[0]), 32'd0);
    chk("rd_w3_wait", 32'(wt_lo[3]), 32'd3);
    chk("rd_w3_oe",   32'(oe_lo[3]), 32'd4);

    // Memory write 0x55 -> 0x000F
    w0 = g[2].wcnt;
    bus(0, 1, 1, 0, 1, 1, 16'h000F, 8'h55, 8);
    chk("wr_w2_we",   32'(we_lo[2]), 32'd3);
    chk("wr_w2_wait", 32'(wt_lo[2]), 32'd2);
    chk("wr_w2_oe",   32'(oe_lo[2]), 32'd0);
    chk("wr_w2_cnt",  32'(g[2].wcnt - w0), 32'd1);
    chk("wr_w2_mem",  32'(g[2].mem[15]), 32'h55);
    chk("wr_w2_sa",   32'(sa_w[2]),  32'h000F);
    chk("wr_w2_sdo",  32'(sdo_w[2]), 32'h55);

    // OUT (0xFE),0x1A
    bus(1, 0, 1, 0, 1, 1, 16'h00FE, 8'h1A, 4);
    chk("out_border", 32'(border_w[1]), 32'h2);
    chk("out_mic",    32'(mic_w[1]),    32'h1);
    chk("out_spk",    32'(spk_w[1]),    32'h1);
    chk("out_wait",   32'(wt_lo[1]),    32'd0);
    chk("out_nomem",  32'(we_lo[1] + oe_lo[1]), 32'd0);

    // IN port 0xFE / 0x01 / interrupt acknowledge
    bus(1, 0, 0, 1, 1, 1, 16'h00FE, 8'h00, 4);
    chk("in_fe",   32'(di_w[1]), 32'hBF);
    bus(1, 0, 0, 1, 1, 1, 16'h0001, 8'h00, 4);
    chk("in_01",   32'(di_w[1]), 32'hFF);
    bus(1, 0, 0, 1, 1, 1, 16'h00FE, 8'h00, 4);
    chk("in_fe2",  32'(di_w[1]), 32'hBF);
    bus(1, 0, 1, 1, 0, 1, 16'h0000, 8'h00, 4);
    chk("inta",    32'(di_w[1]), 32'hFF);

    // Refresh cycle never touches SRAM
    bus(0, 1, 0, 1, 0, 0, 16'h0001, 8'h00, 4);
    chk("rfsh_oe",   32'(oe_lo[1] + oe_lo[3]), 32'd0);
    chk("rfsh_we",   32'(we_lo[1] + we_lo[3]), 32'd0);
    chk("rfsh_wait", 32'(wt_lo[3]), 32'd0);

    // Simultaneous mreq and iorq: memory wins
    bus(1, 0, 0, 1, 1, 1, 16'h00FE, 8'h00, 4);
    bus(0, 0, 0, 1, 1, 1, 16'h0002, 8'h00, 8);
    chk("prio_di", 32'(di_w[1]), 32'h3C);

    // Strobe dropped after one clock: WAITS=3 access still completes
    bus(0, 1, 0, 1, 1, 1, 16'h0001, 8'h00, 1);
    chk("abort_di", 32'(di_w[3]), 32'h0F);
    chk("abort_oe", 32'(oe_w[3]),  32'h1);

    chk("excl", 32'(both_lo), 32'd0);

    // Reset during a WAITS=3 write, before any edge samples the strobe
    @(negedge clk);
    mreq_n = 1'b0; wr_n = 1'b0; A = 16'h0020; dout = 8'hAA;
    @(posedge clk);
    #2;
    chk("mid_we_pre", 32'(we_w[3]), 32'h0);
    reset_n = 1'b0;
    #1;
    chk("mid_we",     32'(we_w[3]),     32'h1);
    chk("mid_wait",   32'(wait_w[3]),   32'h1);
    chk("mid_border", 32'(border_w[3]), 32'h0);
    @(negedge clk);
    idle_bus();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_mem",  32'(g[3].mem[32]), 32'h00);
    chk("mid_idle", 32'(we_w[3]), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
